uart_tx_arbiter: RTL
====================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one UART transmitter.
REQ-002 Parameter MAX_BURST, default 16: maximum bytes sent under one grant before forced release.
REQ-003 Parameter HOLD_TIMEOUT, default 255: cycles a mid-burst grant is held waiting for the next byte.
REQ-004 i_Clock  input  1  single clock; all logic on rising edge.
REQ-005 i_Rst_n  input  1  reset, asynchronous, active-low.
REQ-006 i_Req_Valid  input  NUM_REQ  per-requester byte available.
REQ-007 i_Req_Byte  input  8*NUM_REQ  per-requester byte; requester k on bits [8k+7:8k].
REQ-008 i_Req_Last  input  NUM_REQ  byte is the last of the requester's message.
REQ-009 o_Req_Ready  output  NUM_REQ  byte accepted this cycle; one-hot or zero.
REQ-010 o_Grant  output  NUM_REQ  current owner of the transmitter; one-hot or zero.
REQ-011 o_Tx_DV  output  1  one-cycle start pulse to the UART transmitter.
REQ-012 o_Tx_Byte  output  8  byte for the transmitter, stable from o_Tx_DV until i_Tx_Done.
REQ-013 i_Tx_Active  input  1  transmitter busy.
REQ-014 i_Tx_Done  input  1  one-cycle pulse, transmission complete.
REQ-015 o_Busy  output  1  high in any state other than S_IDLE.

Function
REQ-016 States SHALL be S_IDLE, S_LOAD, S_START, S_WAIT_DONE.
REQ-017 S_IDLE: if any i_Req_Valid, grant the first valid requester at or after rr_ptr (wrapping modulo NUM_REQ), set o_Grant, clear burst count, go to S_LOAD; otherwise stay.
REQ-018 S_LOAD, granted g: o_Req_Ready[g] = i_Req_Valid[g] AND NOT i_Tx_Active (combinational); on a handshake capture i_Req_Byte[g] into o_Tx_Byte and i_Req_Last[g] into a last flag, increment burst count, go to S_START.
REQ-019 S_LOAD without a handshake: increment hold counter; when it reaches HOLD_TIMEOUT, release the grant and go to S_IDLE; the hold counter clears on every entry to S_LOAD.
REQ-020 S_START: assert o_Tx_DV for exactly one cycle, go to S_WAIT_DONE.
REQ-021 S_WAIT_DONE: on i_Tx_Done, release if last flag set or burst count == MAX_BURST, else return to S_LOAD keeping the grant.
REQ-022 Release SHALL clear o_Grant, set rr_ptr to (g+1) mod NUM_REQ, and enter S_IDLE.
REQ-023 Latency: valid asserted in S_IDLE at cycle N -> o_Grant/o_Req_Ready at N+1 -> o_Tx_DV at N+2.
REQ-024 o_Req_Ready SHALL be 0 for every non-granted requester and outside S_LOAD.
REQ-025 Requests from non-granted requesters SHALL NOT interleave bytes into a granted burst.
REQ-026 Withdrawal of i_Req_Valid by the granted requester mid-burst SHALL be handled only by the timeout (REQ-019).
REQ-027 i_Tx_Done outside S_WAIT_DONE SHALL be ignored.
REQ-028 Burst counter width SHALL be clog2(MAX_BURST+1); hold counter width SHALL be clog2(HOLD_TIMEOUT+1); no wrap-around is permitted.

Reset
REQ-029 On i_Rst_n low: state S_IDLE, o_Grant 0, o_Req_Ready 0, o_Tx_DV 0, o_Tx_Byte 8'h00, o_Busy 0, rr_ptr 0, counters 0, last flag 0.
REQ-030 Reset asserted mid-transmission SHALL abort immediately, with no o_Tx_DV issued after deassertion until a new request arrives.

Structure
REQ-031 State encodings and default parameter values SHALL live in shared package uart_pkg.
REQ-032 Round-robin selection SHALL be a sub-module uart_rr_arbiter (inputs: request vector, rr_ptr; output: one-hot pick).

Verification
REQ-033 Single request: requester 2 sends 8'hA5 with Last=1 -> o_Grant=4'b0100 at N+1, o_Tx_DV at N+2 with o_Tx_Byte=8'hA5, release after i_Tx_Done, rr_ptr=3.
REQ-034 Contention: all four valid with Last=1 from rr_ptr=0 -> grants in order 0,1,2,3,0.
REQ-035 Burst lock: requester 1 sends 3 bytes (Last on the third) while requester 0 is valid -> requester 0 receives no ready until after the third i_Tx_Done.
REQ-036 MAX_BURST=4, requester 3 streams 6 bytes with no Last -> release after the 4th byte, then re-grant per round-robin.
REQ-037 Timeout: granted requester drops valid mid-burst -> release after exactly HOLD_TIMEOUT cycles in S_LOAD, o_Busy falls.
REQ-038 Reset in S_WAIT_DONE -> all outputs at reset values asynchronously, and a spurious i_Tx_Done afterwards is ignored.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding, default
// parameter values and a pointer-width helper.
package uart_pkg;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LOAD      = 2'd1,
        S_START     = 2'd2,
        S_WAIT_DONE = 2'd3
    } uart_arb_state_t;

    localparam int DEF_NUM_REQ      = 4;
    localparam int DEF_MAX_BURST    = 16;
    localparam int DEF_HOLD_TIMEOUT = 255;

    // A single requester still needs a one-bit pointer.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Round-robin pick: first requester at or after rr_ptr, wrapping modulo
// NUM_REQ. Purely combinational; the pointer is owned by the caller.
module uart_rr_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int PTR_W   = ptr_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] pick
);

    logic [PTR_W-1:0] cand;
    logic             found;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = PTR_W'((int'(rr_ptr) + i) % NUM_REQ);
            if (!found && req[cand]) begin
                pick[cand] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NUM_REQ byte sources. A grant covers a
// burst of bytes, ending on Last, MAX_BURST bytes, or a hold timeout.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = DEF_NUM_REQ,
    parameter int MAX_BURST    = DEF_MAX_BURST,
    parameter int HOLD_TIMEOUT = DEF_HOLD_TIMEOUT,
    parameter int PTR_W        = ptr_width(NUM_REQ)
) (
    input  logic                   i_Clock,
    input  logic                   i_Rst_n,
    input  logic [NUM_REQ-1:0]     i_Req_Valid,
    input  logic [8*NUM_REQ-1:0]   i_Req_Byte,
    input  logic [NUM_REQ-1:0]     i_Req_Last,
    output logic [NUM_REQ-1:0]     o_Req_Ready,
    output logic [NUM_REQ-1:0]     o_Grant,
    output logic                   o_Tx_DV,
    output logic [7:0]             o_Tx_Byte,
    input  logic                   i_Tx_Active,
    input  logic                   i_Tx_Done,
    output logic                   o_Busy,
    output uart_arb_state_t        o_State,
    output logic [PTR_W-1:0]       o_Rr_Ptr
);

    localparam int BURST_W = $clog2(MAX_BURST + 1);
    localparam int HOLD_W  = $clog2(HOLD_TIMEOUT + 1);
    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);
    localparam logic [HOLD_W-1:0]  HOLD_MAX  = HOLD_W'(HOLD_TIMEOUT);

    uart_arb_state_t      state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [PTR_W-1:0]     gidx_q, gidx_d;
    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [BURST_W-1:0]   burst_q, burst_d;
    logic [HOLD_W-1:0]    hold_q, hold_d;
    logic                 last_q, last_d;
    logic [7:0]           byte_q, byte_d;

    logic [NUM_REQ-1:0]   pick;
    logic [PTR_W-1:0]     pick_idx;
    logic [PTR_W-1:0]     next_ptr;
    logic [NUM_REQ-1:0]   ready;
    logic                 tx_dv;
    logic                 rel_grant;
    logic [7:0]           req_bytes [NUM_REQ];

    uart_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr (
        .req    (i_Req_Valid),
        .rr_ptr (rr_ptr_q),
        .pick   (pick)
    );

    always_comb begin
        pick_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (pick[k]) begin
                pick_idx = PTR_W'(k);
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            req_bytes[k] = i_Req_Byte[8*k +: 8];
        end
    end

    assign next_ptr = (gidx_q == PTR_W'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;

    // Handshake: a byte moves from requester g only in a cycle where
    // i_Req_Valid[g] && o_Req_Ready[g]; ready is offered solely to the
    // granted requester in S_LOAD while the transmitter is idle, and valid
    // may be withdrawn at any time (the hold timeout recovers the grant).
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        gidx_d    = gidx_q;
        rr_ptr_d  = rr_ptr_q;
        burst_d   = burst_q;
        hold_d    = hold_q;
        last_d    = last_q;
        byte_d    = byte_q;
        ready     = '0;
        tx_dv     = 1'b0;
        rel_grant = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (|i_Req_Valid) begin
                    grant_d = pick;
                    gidx_d  = pick_idx;
                    burst_d = '0;
                    hold_d  = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                ready[gidx_q] = i_Req_Valid[gidx_q] & ~i_Tx_Active;
                if (ready[gidx_q]) begin
                    byte_d  = req_bytes[gidx_q];
                    last_d  = i_Req_Last[gidx_q];
                    burst_d = burst_q + 1'b1;
                    state_d = S_START;
                end else if (hold_q + 1'b1 == HOLD_MAX) begin
                    rel_grant = 1'b1;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            S_START: begin
                tx_dv   = 1'b1;
                state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (i_Tx_Done) begin
                    if (last_q || (burst_q == BURST_MAX)) begin
                        rel_grant = 1'b1;
                    end else begin
                        hold_d  = '0;
                        state_d = S_LOAD;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Hand the pointer past the releasing owner so it goes to the back.
        if (rel_grant) begin
            grant_d  = '0;
            rr_ptr_d = next_ptr;
            burst_d  = '0;
            hold_d   = '0;
            state_d  = S_IDLE;
        end
    end

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q  <= S_IDLE;
            grant_q  <= '0;
            gidx_q   <= '0;
            rr_ptr_q <= '0;
            burst_q  <= '0;
            hold_q   <= '0;
            last_q   <= 1'b0;
            byte_q   <= 8'h00;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            gidx_q   <= gidx_d;
            rr_ptr_q <= rr_ptr_d;
            burst_q  <= burst_d;
            hold_q   <= hold_d;
            last_q   <= last_d;
            byte_q   <= byte_d;
        end
    end

    assign o_Req_Ready = ready;
    assign o_Grant     = grant_q;
    assign o_Tx_DV     = tx_dv;
    assign o_Tx_Byte   = byte_q;
    assign o_Busy      = (state_q != S_IDLE);
    assign o_State     = state_q;
    assign o_Rr_Ptr    = rr_ptr_q;

endmodule
